// File: rtl/digest_reader.sv
// Snapshots a packed hash digest on start and streams it out one 32-bit word
// per ready/valid handshake, H0 first, followed by a single-cycle done pulse.
module digest_reader #(
  parameter int unsigned NUM_WORDS = 8,
  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic                      start,
  input  logic [32*NUM_WORDS-1:0]   digest_in,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [31:0]               out_data,
  output logic [IDX_W-1:0]          out_index,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [31:0]      snap [NUM_WORDS];
  logic             at_last;
  logic             xfer;

  assign at_last = (idx == IDX_W'(NUM_WORDS - 1));
  assign xfer    = out_valid & out_ready;

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) state <= IDLE;
    else             state <= state_nxt;
  end

  // All outputs decode from the state register, so asserting reset clears
  // them combinationally without waiting for an edge.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = SEND;
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready && at_last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_data  = snap[idx];
      out_index = idx;
      out_last  = at_last;
    end
  end

  // Word 0 lives in the top 32 bits of digest_in.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      idx <= '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) snap[i] <= '0;
    end else if (state == IDLE && start) begin
      idx <= '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++)
        snap[i] <= digest_in[(NUM_WORDS-1-i)*32 +: 32];
    end else if (xfer && !at_last) begin
      idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_digest_reader.sv
// Self-checking bench for digest_reader: directed SHA-256 IV stream plus
// randomized digests and ready patterns against a queue-based word model.
module tb_digest_reader;

  localparam int NW = 8;
  localparam int IW = $clog2(NW);
  localparam int DW = 32 * NW;

  logic          clock;
  logic          ctrl_reset;
  logic          start;
  logic [DW-1:0] digest_in;
  logic          out_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  digest_reader #(.NUM_WORDS(NW)) dut (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .start     (start),
    .digest_in (digest_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [DW-1:0] rand_digest();
    logic [DW-1:0] d;
    for (int i = 0; i < NW; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic check_idle_outputs(input string tag);
    n_checks++;
    if ({out_valid, out_data, out_index, out_last, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL %s: valid=%b data=%h idx=%0d last=%b busy=%b done=%b, required all 0",
               tag, out_valid, out_data, out_index, out_last, busy, done);
    end
  endtask

  // Streams one digest; inputs change on negedges, outputs are checked there.
  task automatic stream_check(input logic [DW-1:0] d, input int ready_pct,
                              input bit poison, input bit poke_start, input bit stall2);
    logic [31:0] exp_q[$];
    int   k, stall, cycles;
    logic rdy;
    for (int i = 0; i < NW; i++) exp_q.push_back(d[(NW-1-i)*32 +: 32]);
    @(negedge clock);
    start = 1'b1; digest_in = d; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    if (poison) digest_in = '1;
    k = 0; stall = 0; cycles = 0;
    while (k < NW && cycles < 400) begin
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_ctl k=%0d: valid=%b busy=%b done=%b, required 1 1 0",
                 k, out_valid, busy, done);
      end
      n_checks++;
      if (out_data !== exp_q[k]) begin
        n_fail++;
        $display("FAIL stream_data k=%0d: got %h, required %h", k, out_data, exp_q[k]);
      end
      n_checks++;
      if (out_index !== IW'(k) || out_last !== (k == NW-1)) begin
        n_fail++;
        $display("FAIL stream_idx k=%0d: idx=%0d last=%b, required idx=%0d last=%b",
                 k, out_index, out_last, k, (k == NW-1));
      end
      if (stall2 && k == 2 && stall < 3) begin
        rdy = 1'b0; stall++;
      end else begin
        rdy = ($urandom_range(99) < ready_pct);
      end
      start     = (poke_start && k == 3);
      out_ready = rdy;
      @(negedge clock);
      cycles++;
      if (rdy) k++;
    end
    n_checks++;
    if (k != NW) begin
      n_fail++;
      $display("FAIL stream_timeout: transferred %0d words, required %0d", k, NW);
    end
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 ||
        out_data !== 32'h0 || out_index !== '0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL done_cycle: done=%b busy=%b valid=%b data=%h idx=%0d last=%b, required 1 1 0 0 0 0",
               done, busy, out_valid, out_data, out_index, out_last);
    end
    if (poke_start) start = 1'b1;
    out_ready = $urandom_range(1);
    @(negedge clock);
    start = 1'b0;
    check_idle_outputs("after_done");
    @(negedge clock);
    check_idle_outputs("stays_idle");
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b0; start = 1'b0; out_ready = 1'b0; digest_in = '0;
    #3;
    check_idle_outputs("reset_state");
    @(negedge clock);
    start = 1'b1; digest_in = rand_digest(); out_ready = 1'b1;
    @(negedge clock);
    check_idle_outputs("reset_holds");
    start = 1'b0;
    ctrl_reset = 1'b1;
    @(negedge clock);
    check_idle_outputs("release_no_start");
  endtask

  task automatic test_basic();
    logic [DW-1:0] iv;
    iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    stream_check(iv, 100, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] iv;
    iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    stream_check(iv, 100, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_snapshot();
    stream_check(rand_digest(), 100, 1'b1, 1'b0, 1'b0);
    stream_check(rand_digest(), 50, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    stream_check(rand_digest(), 100, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    int cyc;
    d = rand_digest();
    @(negedge clock);
    start = 1'b1; digest_in = d; out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (out_index !== IW'(4) && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    n_checks++;
    if (out_index !== IW'(4) || out_data !== d[(NW-1-4)*32 +: 32]) begin
      n_fail++;
      $display("FAIL reach_idx4: idx=%0d data=%h, required 4 %h",
               out_index, out_data, d[(NW-1-4)*32 +: 32]);
    end
    #2 ctrl_reset = 1'b0;
    #1 check_idle_outputs("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_idle_outputs("reset_no_done");
    end
    ctrl_reset = 1'b1;
    @(negedge clock);
    check_idle_outputs("no_resume");
    ctrl_reset = 1'b0;
    @(negedge clock);
    d = rand_digest();
    ctrl_reset = 1'b1; start = 1'b1; digest_in = d;
    @(negedge clock);
    start = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_index !== '0 || out_data !== d[DW-1 -: 32]) begin
      n_fail++;
      $display("FAIL first_edge_start: valid=%b idx=%0d data=%h, required 1 0 %h",
               out_valid, out_index, out_data, d[DW-1 -: 32]);
    end
    ctrl_reset = 1'b0;
    #1 ctrl_reset = 1'b1;
    stream_check(rand_digest(), 100, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++)
      stream_check(rand_digest(), $urandom_range(30, 90), $urandom_range(1),
                   $urandom_range(1), 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
